// File: rtl/card_hand_datapath.sv
// Purpose : six-slot card store (3 player, 3 dealer) feeding the game FSM; scores, third-card value, 7-seg drive, protocol check.
// Latency : loads take effect on the rising slow_clock edge; all outputs are combinational from the slot registers.
// Backpres: none; strobes are accepted every cycle, and illegal strobes are dropped and latch protocol_err.
//
// Ports:
//   slow_clock, resetb          clock, async active-low reset
//   new_card[3:0]               rank on offer (1=A .. 13=K)
//   load_pcard1..3, load_dcard1..3
//                               capture strobes, at most one per cycle
//   pscore, dscore              hand scores 0..9
//   pcard3                      value of player card 3 (0 if empty)
//   cards_dealt                 occupied slot count 0..6
//   protocol_err                sticky dealing-violation flag
//   HEX0..HEX5                  {g,f,e,d,c,b,a}; HEX0..2 player 1..3, HEX3..5 dealer 1..3
module card_hand_datapath #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] new_card,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [3:0] pcard3,
  output logic [2:0] cards_dealt,
  output logic       protocol_err,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  // Slot order everywhere: 0..2 = player cards 1..3, 3..5 = dealer cards 1..3.
  logic [3:0] slot_rank [6];
  logic [5:0] slot_vld;
  logic       err_q;

  logic [5:0] load_vec;
  logic       one_hot;
  logic       rank_ok;
  logic       slot_free;
  logic       load_ok;
  logic       load_bad;

  // Segment patterns below are active-low; XOR with this mask flips polarity.
  localparam logic [6:0] SEG_MASK = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;

  function automatic logic [3:0] card_value(input logic vld, input logic [3:0] rank);
    // Face cards and tens count zero in baccarat.
    if (vld && (rank >= 4'd1) && (rank <= 4'd9)) begin
      card_value = rank;
    end else begin
      card_value = 4'd0;
    end
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] sum;
    // Max 27, so at most two subtractions of 10 are needed for mod 10.
    sum = {1'b0, a} + {1'b0, b} + {1'b0, c};
    if (sum >= 5'd20) begin
      sum = sum - 5'd20;
    end else if (sum >= 5'd10) begin
      sum = sum - 5'd10;
    end
    hand_score = sum[3:0];
  endfunction

  function automatic logic [6:0] seg_decode(input logic vld, input logic [3:0] rank);
    logic [6:0] seg;
    if (!vld) begin
      seg = 7'b1111111;
    end else begin
      case (rank)
        4'd1:    seg = 7'b0001000;  // A
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        4'd10:   seg = 7'b1000000;  // shown as 0
        4'd11:   seg = 7'b1100001;  // J
        4'd12:   seg = 7'b0011000;  // Q
        4'd13:   seg = 7'b0001001;  // K
        default: seg = 7'b1111111;
      endcase
    end
    seg_decode = seg ^ SEG_MASK;
  endfunction

  // Load legality: a single strobe, a real rank, and an empty target unless it is
  // player card 1 (which opens a new round and may overwrite).
  always_comb begin
    load_vec  = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
    one_hot   = (load_vec != 6'd0) && ((load_vec & (load_vec - 6'd1)) == 6'd0);
    rank_ok   = (new_card >= 4'd1) && (new_card <= 4'd13);
    slot_free = load_vec[0] || ((load_vec & slot_vld) == 6'd0);
    load_ok   = one_hot && rank_ok && slot_free;
    load_bad  = (load_vec != 6'd0) && !load_ok;
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 6; i++) begin
        slot_rank[i] <= 4'd0;
      end
      slot_vld <= 6'd0;
      err_q    <= 1'b0;
    end else begin
      if (load_bad) begin
        err_q <= 1'b1;
      end
      if (load_ok) begin
        for (int i = 0; i < 6; i++) begin
          if (load_vec[i]) begin
            slot_rank[i] <= new_card;
            slot_vld[i]  <= 1'b1;
          end else if (load_vec[0]) begin
            // New round: wipe every other slot on the same edge.
            slot_rank[i] <= 4'd0;
            slot_vld[i]  <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    cards_dealt = 3'd0;
    for (int i = 0; i < 6; i++) begin
      cards_dealt = cards_dealt + {2'b00, slot_vld[i]};
    end
  end

  assign pscore = hand_score(card_value(slot_vld[0], slot_rank[0]),
                             card_value(slot_vld[1], slot_rank[1]),
                             card_value(slot_vld[2], slot_rank[2]));
  assign dscore = hand_score(card_value(slot_vld[3], slot_rank[3]),
                             card_value(slot_vld[4], slot_rank[4]),
                             card_value(slot_vld[5], slot_rank[5]));
  assign pcard3       = card_value(slot_vld[2], slot_rank[2]);
  assign protocol_err = err_q;

  assign HEX0 = seg_decode(slot_vld[0], slot_rank[0]);
  assign HEX1 = seg_decode(slot_vld[1], slot_rank[1]);
  assign HEX2 = seg_decode(slot_vld[2], slot_rank[2]);
  assign HEX3 = seg_decode(slot_vld[3], slot_rank[3]);
  assign HEX4 = seg_decode(slot_vld[4], slot_rank[4]);
  assign HEX5 = seg_decode(slot_vld[5], slot_rank[5]);

endmodule

// File: tb/tb_card_hand_datapath.sv
// Bench for card_hand_datapath: directed round walk-through, protocol violations,
// async reset, then randomized strobes/ranks compared against a behavioural model.
module tb_card_hand_datapath;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b1;
  logic [3:0] new_card   = 4'd0;
  logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
  logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
  logic [3:0] pscore, dscore, pcard3;
  logic [2:0] cards_dealt;
  logic       protocol_err;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  card_hand_datapath #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .slow_clock  (slow_clock),
    .resetb      (resetb),
    .new_card    (new_card),
    .load_pcard1 (load_pcard1),
    .load_pcard2 (load_pcard2),
    .load_pcard3 (load_pcard3),
    .load_dcard1 (load_dcard1),
    .load_dcard2 (load_dcard2),
    .load_dcard3 (load_dcard3),
    .pscore      (pscore),
    .dscore      (dscore),
    .pcard3      (pcard3),
    .cards_dealt (cards_dealt),
    .protocol_err(protocol_err),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .HEX4        (HEX4),
    .HEX5        (HEX5)
  );

  always #5 slow_clock = ~slow_clock;

  logic [6:0] hex_obs [6];
  assign hex_obs[0] = HEX0;
  assign hex_obs[1] = HEX1;
  assign hex_obs[2] = HEX2;
  assign hex_obs[3] = HEX3;
  assign hex_obs[4] = HEX4;
  assign hex_obs[5] = HEX5;

  // Expected active-low glyph per rank; 0, 14, 15 are blank.
  logic [6:0] seg_tbl [16] = '{
    7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
    7'b0011000, 7'b0001001, 7'b1111111, 7'b1111111
  };

  // Reference model: slot 0..2 player 1..3, 3..5 dealer 1..3.
  int m_rank [6];
  bit m_vld  [6];
  bit m_err;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mval(input int i);
    if (m_vld[i] && m_rank[i] >= 1 && m_rank[i] <= 9) return m_rank[i];
    return 0;
  endfunction

  function automatic int mhex(input int i);
    if (!m_vld[i]) return 7'h7F;
    return int'(seg_tbl[m_rank[i]]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 6; i++) begin
      m_rank[i] = 0;
      m_vld[i]  = 0;
    end
    m_err = 0;
  endtask

  task automatic model_load(input bit [5:0] ld, input int card);
    int n;
    int idx;
    bit legal;
    n   = $countones(ld);
    idx = 0;
    if (n == 0) return;
    for (int i = 0; i < 6; i++) if (ld[i]) idx = i;
    legal = (n == 1) && (card >= 1) && (card <= 13) && (idx == 0 || !m_vld[idx]);
    if (!legal) begin
      m_err = 1;
    end else begin
      if (idx == 0) for (int i = 1; i < 6; i++) begin
        m_rank[i] = 0;
        m_vld[i]  = 0;
      end
      m_rank[idx] = card;
      m_vld[idx]  = 1;
    end
  endtask

  task automatic check_all(input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 6; i++) cnt += m_vld[i];
    check({tag, ".pscore"}, pscore, (mval(0) + mval(1) + mval(2)) % 10);
    check({tag, ".dscore"}, dscore, (mval(3) + mval(4) + mval(5)) % 10);
    check({tag, ".pcard3"}, pcard3, mval(2));
    check({tag, ".dealt"},  cards_dealt, cnt);
    check({tag, ".err"},    protocol_err, m_err);
    for (int i = 0; i < 6; i++) check($sformatf("%s.hex%0d", tag, i), hex_obs[i], mhex(i));
  endtask

  task automatic set_loads(input bit [5:0] ld);
    load_pcard1 = ld[0];
    load_pcard2 = ld[1];
    load_pcard3 = ld[2];
    load_dcard1 = ld[3];
    load_dcard2 = ld[4];
    load_dcard3 = ld[5];
  endtask

  // Called at posedge+1: drive, take the edge, update model, check at posedge+1.
  task automatic apply(input bit [5:0] ld, input int card, input string tag);
    set_loads(ld);
    new_card = card[3:0];
    @(posedge slow_clock);
    model_load(ld, card);
    #1;
    set_loads(6'd0);
    check_all(tag);
  endtask

  // Mid-cycle async reset; an edge with a strobe while resetb is low must be ignored.
  task automatic async_reset(input string tag);
    #2;
    resetb = 1'b0;
    #1;
    model_clear();
    check_all({tag, ".async"});
    set_loads(6'b000001);
    new_card = 4'd5;
    @(posedge slow_clock);
    #1;
    check_all({tag, ".held"});
    set_loads(6'd0);
    @(negedge slow_clock);
    resetb = 1'b1;
    @(posedge slow_clock);
    #1;
    check_all({tag, ".rel"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [5:0] ld;
    int card;
    int r;

    // Power-up reset.
    #2;
    resetb = 1'b0;
    #1;
    model_clear();
    check_all("por");
    @(negedge slow_clock);
    resetb = 1'b1;
    @(posedge slow_clock);
    #1;

    // Random register state, then reset.
    for (int i = 0; i < 8; i++) apply(6'b1 << $urandom_range(0, 5), $urandom_range(1, 13), "pre");
    async_reset("rst1");
    check("rst1.hex0_lit", HEX0, 7'h7F);

    // Directed round.
    apply(6'b000001, 13, "p1");
    apply(6'b001000, 9,  "d1");
    apply(6'b000010, 7,  "p2");
    apply(6'b010000, 8,  "d2");
    check("deal4.pscore", pscore, 7);
    check("deal4.dscore", dscore, 7);
    check("deal4.dealt",  cards_dealt, 4);
    check("deal4.hex0",   HEX0, 7'b0001001);
    check("deal4.hex3",   HEX3, 7'b0010000);
    apply(6'b000100, 5,  "p3");
    check("p3.pcard3", pcard3, 5);
    check("p3.pscore", pscore, 2);
    apply(6'b100000, 11, "d3");
    check("d3.dscore", dscore, 7);
    check("d3.dealt",  cards_dealt, 6);
    apply(6'b000001, 1,  "newround");
    check("newround.dealt",  cards_dealt, 1);
    check("newround.pscore", pscore, 1);
    check("newround.dscore", dscore, 0);
    check("newround.hex5",   HEX5, 7'h7F);

    // Violations.
    apply(6'b010010, 4,  "twostrobe");
    check("twostrobe.err",   protocol_err, 1);
    check("twostrobe.dealt", cards_dealt, 1);
    apply(6'b001000, 14, "rank14");
    check("rank14.hex3", HEX3, 7'h7F);
    async_reset("rst2");
    check("rst2.err", protocol_err, 0);
    apply(6'b001000, 6,  "d1load");
    apply(6'b001000, 3,  "d1reload");
    check("d1reload.hex3", HEX3, 7'b0000010);
    check("d1reload.err",  protocol_err, 1);
    async_reset("rst3");

    // Randomized phase.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 15);
      if (r < 2)      ld = 6'd0;
      else if (r < 4) ld = (6'b1 << $urandom_range(0, 5)) | (6'b1 << $urandom_range(0, 5));
      else            ld = 6'b1 << $urandom_range(0, 5);
      card = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 13);
      apply(ld, card, "rnd");
      if ($urandom_range(0, 63) == 0) async_reset("rndrst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
